// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared FSM state encoding and op-counter width for the AES request arbiter
package aes_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        RESP = 2'd3
    } arb_state_t;
    localparam int OP_CNT_W = 16;
endpackage

// File: rtl/aes_rr_arbiter.sv
// aes_rr_arbiter: 2-way round-robin grant with last_grant register
// Ports: clk, reset (async active-low), en (grant allowed), req0/req1 (requests),
//        gnt0/gnt1 (one-hot grant, combinational)
module aes_rr_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);
    logic last_grant;
    logic pick1;
    // req1 wins when alone, or when both contend and req0 had the last grant
    assign pick1 = req1 & (~req0 | ~last_grant);
    assign gnt0  = en & req0 & ~pick1;
    assign gnt1  = en & pick1;
    always_ff @(posedge clk or negedge reset)
        if (!reset) last_grant <= 1'b1;
        else if (gnt0 | gnt1) last_grant <= gnt1;
endmodule

// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: shares one AES core between two requesters (IDLE->LOAD->BUSY->RESP)
// Ports: clk, reset (async active-low); reqN_valid_i/decrypt_i/data_i/key_i, reqN_ack_o;
//        resp_valid_o/id_o/data_o/err_o, resp_accept_i; aes_load_o/decrypt_o/data_o/key_o,
//        aes_ready_i/data_i; busy_o, op_count_o.
// Option: define AES_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES with resp_err_o=1.
module aes_req_arbiter
    import aes_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid_i,
    input  logic                req0_decrypt_i,
    input  logic [127:0]        req0_data_i,
    input  logic [127:0]        req0_key_i,
    output logic                req0_ack_o,
    input  logic                req1_valid_i,
    input  logic                req1_decrypt_i,
    input  logic [127:0]        req1_data_i,
    input  logic [127:0]        req1_key_i,
    output logic                req1_ack_o,
    output logic                resp_valid_o,
    output logic                resp_id_o,
    output logic [127:0]        resp_data_o,
    output logic                resp_err_o,
    input  logic                resp_accept_i,
    output logic                aes_load_o,
    output logic                aes_decrypt_o,
    output logic [127:0]        aes_data_o,
    output logic [127:0]        aes_key_o,
    input  logic                aes_ready_i,
    input  logic [127:0]        aes_data_i,
    output logic                busy_o,
    output logic [OP_CNT_W-1:0] op_count_o
);
    arb_state_t          state, state_nx;
    logic                gnt0, gnt1, grant, tmo;
    logic                id_q, dec_q;
    logic [127:0]        data_q, key_q, rdata_q;
    logic [OP_CNT_W-1:0] cnt_q;

    // grants only in IDLE and never while reset is held
    aes_rr_arbiter u_rr (
        .clk  (clk),
        .reset(reset),
        .en   (state == IDLE && reset),
        .req0 (req0_valid_i),
        .req1 (req1_valid_i),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );
    assign grant = gnt0 | gnt1;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = LOAD;
            LOAD:    state_nx = BUSY;
            BUSY:    if (aes_ready_i || tmo) state_nx = RESP;
            RESP:    if (resp_accept_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            id_q    <= 1'b0;
            dec_q   <= 1'b0;
            data_q  <= '0;
            key_q   <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (grant) begin
                id_q   <= gnt1;
                dec_q  <= gnt1 ? req1_decrypt_i : req0_decrypt_i;
                data_q <= gnt1 ? req1_data_i : req0_data_i;
                key_q  <= gnt1 ? req1_key_i : req0_key_i;
            end
            if (state == BUSY && aes_ready_i) begin
                rdata_q <= aes_data_i;
                cnt_q   <= cnt_q + OP_CNT_W'(1);
            end else if (state == BUSY && tmo) begin
                rdata_q <= '0;
            end
        end

`ifdef AES_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          err_q;
    // tmo_q counts completed BUSY cycles, so the limit is hit in the TIMEOUT_CYCLES-th one
    assign tmo = state == BUSY && !aes_ready_i && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= state == LOAD ? '0 : state == BUSY ? tmo_q + TW'(1) : tmo_q;
            if (state == BUSY && (aes_ready_i || tmo)) err_q <= tmo;
            else if (grant) err_q <= 1'b0;
        end
    assign resp_err_o = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo        = 1'b0;
    assign resp_err_o = 1'b0;
`endif

    assign req0_ack_o    = gnt0;
    assign req1_ack_o    = gnt1;
    assign resp_valid_o  = state == RESP;
    assign resp_id_o     = id_q;
    assign resp_data_o   = rdata_q;
    assign aes_load_o    = state == LOAD;
    assign aes_decrypt_o = dec_q;
    assign aes_data_o    = data_q;
    assign aes_key_o     = key_q;
    assign busy_o        = state != IDLE;
    assign op_count_o    = cnt_q;
endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb_aes_req_arbiter: table-driven scoreboard bench with a behavioural AES core stand-in
module tb_aes_req_arbiter;
    typedef struct {
        logic v0, v1, d0, d1;
        logic [127:0] data0, data1, key;
        logic exp_id;
    } vec_t;
    typedef struct {
        logic id;
        logic [127:0] data;
    } exp_t;

    localparam logic [127:0] K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0, reset = 1'b0;
    logic req0_valid_i = 0, req0_decrypt_i = 0, req1_valid_i = 0, req1_decrypt_i = 0;
    logic [127:0] req0_data_i = '0, req0_key_i = '0, req1_data_i = '0, req1_key_i = '0;
    logic req0_ack_o, req1_ack_o, resp_valid_o, resp_id_o, resp_err_o, resp_accept_i = 0;
    logic [127:0] resp_data_o, aes_data_o, aes_key_o, aes_data_i;
    logic aes_load_o, aes_decrypt_o, aes_ready_i, busy_o;
    logic [15:0] op_count_o;

    logic core_en = 1, core_rdy = 0, stray_rdy = 0, core_bad = 0, ld_dec = 0;
    logic [127:0] core_dat = '0, stray_dat = '0, ld_data = '0, ld_key = '0;
    assign aes_ready_i = core_rdy | stray_rdy;
    assign aes_data_i  = core_rdy ? core_dat : stray_dat;

    int pass_n = 0, total_n = 0;
    logic [15:0] exp_cnt = '0;
    exp_t sb[$];
    vec_t tbl[8];

    aes_req_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid_i(req0_valid_i), .req0_decrypt_i(req0_decrypt_i),
        .req0_data_i(req0_data_i), .req0_key_i(req0_key_i), .req0_ack_o(req0_ack_o),
        .req1_valid_i(req1_valid_i), .req1_decrypt_i(req1_decrypt_i),
        .req1_data_i(req1_data_i), .req1_key_i(req1_key_i), .req1_ack_o(req1_ack_o),
        .resp_valid_o(resp_valid_o), .resp_id_o(resp_id_o), .resp_data_o(resp_data_o),
        .resp_err_o(resp_err_o), .resp_accept_i(resp_accept_i),
        .aes_load_o(aes_load_o), .aes_decrypt_o(aes_decrypt_o), .aes_data_o(aes_data_o),
        .aes_key_o(aes_key_o), .aes_ready_i(aes_ready_i), .aes_data_i(aes_data_i),
        .busy_o(busy_o), .op_count_o(op_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] aes_model(logic [127:0] d, logic [127:0] k, logic dec);
        if (k == K && !dec && d == P) return C;
        if (k == K && dec && d == C) return P;
        return {d[63:0], d[127:64]} ^ k ^ {128{dec}};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total_n++;
        if (act === req) pass_n++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    // core stand-in: latches operands on the load pulse, answers two cycles later
    initial forever begin
        @(posedge clk); #1;
        if (core_en && aes_load_o) begin
            ld_dec  = aes_decrypt_o;
            ld_data = aes_data_o;
            ld_key  = aes_key_o;
            @(posedge clk); #1;
            if (aes_load_o) core_bad = 1;
            @(posedge clk); #1;
            if ({aes_decrypt_o, aes_data_o, aes_key_o} !== {ld_dec, ld_data, ld_key}) core_bad = 1;
            core_dat = aes_model(ld_data, ld_key, ld_dec);
            core_rdy = 1;
            @(posedge clk); #1;
            core_rdy = 0;
        end
    end

    task automatic do_reset(input string name);
        reset = 0;
        @(posedge clk); #1;
        chk({name, " ctl"}, {req0_ack_o, req1_ack_o, resp_valid_o, resp_id_o, resp_err_o,
            aes_load_o, aes_decrypt_o, busy_o, op_count_o}, '0);
        chk({name, " data"}, resp_data_o | aes_data_o | aes_key_o, '0);
        exp_cnt = '0;
        reset = 1;
    endtask

    task automatic wait_resp(input string name, input int hold);
        logic bad = 0;
        exp_t e;
        for (int t = 0; t < 100 && !resp_valid_o; t++) begin
            if (busy_o && (req0_ack_o || req1_ack_o)) bad = 1;
            @(posedge clk); #1;
        end
        chk({name, " no ack busy"}, bad, 0);
        chk({name, " resp_valid"}, resp_valid_o, 1);
        chk({name, " sb"}, sb.size() != 0, 1);
        e = sb.size() != 0 ? sb.pop_front() : '{1'b0, '0};
        exp_cnt++;
        chk({name, " id"}, resp_id_o, e.id);
        chk({name, " data"}, resp_data_o, e.data);
        chk({name, " err"}, resp_err_o, 0);
        chk({name, " op_count"}, op_count_o, exp_cnt);
        if (hold > 0) begin
            bad = 0;
            req0_valid_i = 1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!resp_valid_o || resp_data_o !== e.data || req0_ack_o || req1_ack_o) bad = 1;
            end
            chk({name, " hold stable"}, bad, 0);
        end
        resp_accept_i = 1;
        @(posedge clk); #1;
        resp_accept_i = 0;
        chk({name, " idle after accept"}, busy_o, 0);
    endtask

    task automatic run_vec(input vec_t v, input string name, input int hold);
        logic got = 0;
        req0_valid_i = v.v0; req0_decrypt_i = v.d0; req0_data_i = v.data0; req0_key_i = v.key;
        req1_valid_i = v.v1; req1_decrypt_i = v.d1; req1_data_i = v.data1; req1_key_i = v.key;
        #1;
        for (int t = 0; t < 50 && !got; t++) begin
            if (req0_ack_o || req1_ack_o) got = 1;
            else begin @(posedge clk); #1; end
        end
        chk({name, " ack"}, {req1_ack_o, req0_ack_o}, v.exp_id ? 2'b10 : 2'b01);
        if (!got) return;
        sb.push_back('{v.exp_id, aes_model(v.exp_id ? v.data1 : v.data0, v.key,
                                             v.exp_id ? v.d1 : v.d0)});
        @(posedge clk); #1;
        if (v.exp_id) req1_valid_i = 0;
        else req0_valid_i = 0;
        wait_resp(name, hold);
    endtask

    initial begin
        vec_t bp, fu;
        int n;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, P, '0, K, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, '0, C, K, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, rnd128(), rnd128(), rnd128(), 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, rnd128(), rnd128(), rnd128(), 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, rnd128(), rnd128(), rnd128(), 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, rnd128(), rnd128(), rnd128(), 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, rnd128(), rnd128(), rnd128(), 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, rnd128(), rnd128(), rnd128(), 1'b0};
        bp     = '{1'b1, 1'b0, 1'b1, 1'b0, rnd128(), '0, rnd128(), 1'b0};
        fu     = '{1'b1, 1'b0, 1'b0, 1'b0, rnd128(), '0, rnd128(), 1'b0};

        do_reset("reset");
        for (int i = 0; i < 8; i++) begin
            if (i == 2) do_reset("reset2");
            run_vec(tbl[i], $sformatf("vec%0d", i), 0);
        end
        req1_valid_i = 0;

        run_vec(bp, "backpressure", 20);
        chk("b2b ack", req0_ack_o, 1);
        run_vec(fu, "followup", 0);

        core_en = 0;
        req0_valid_i = 1; req0_decrypt_i = 0; req0_data_i = P; req0_key_i = K;
        #1;
        chk("mid ack", req0_ack_o, 1);
        @(posedge clk); #1;
        req0_valid_i = 0;
        repeat (2) begin @(posedge clk); #1; end
        chk("mid busy", busy_o, 1);
        do_reset("mid reset");
        stray_dat = rnd128();
        stray_rdy = 1;
        @(posedge clk); #1;
        stray_rdy = 0;
        chk("stray ignored", {resp_valid_o, busy_o, op_count_o, resp_data_o}, '0);
        core_en = 1;
        run_vec(tbl[0], "after reset", 0);

`ifdef AES_ARB_TIMEOUT_EN
        core_en = 0;
        req0_valid_i = 1; req0_data_i = P; req0_key_i = K; req0_decrypt_i = 0;
        #1;
        chk("to ack", req0_ack_o, 1);
        @(posedge clk); #1;
        req0_valid_i = 0;
        n = 0;
        for (int t = 0; t < 100 && !resp_valid_o; t++) begin
            if (busy_o && !aes_load_o) n++;
            @(posedge clk); #1;
        end
        chk("to busy cycles", n, 16);
        chk("to valid", resp_valid_o, 1);
        chk("to err", resp_err_o, 1);
        chk("to data", resp_data_o, '0);
        chk("to op_count", op_count_o, exp_cnt);
        resp_accept_i = 1;
        @(posedge clk); #1;
        resp_accept_i = 0;
        core_en = 1;
`else
        n = 0;
`endif
        chk("core iface", core_bad, 0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/aes_req_arbiter.md
AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 1023, BUSY-state cycle limit when AES_ARB_TIMEOUT_EN is defined.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: reqN_valid_i  input  1  requester N (N=0,1) has an operation pending.
REQ-005 SHALL have ports: reqN_decrypt_i  input  1  1=decrypt, 0=encrypt.
REQ-006 SHALL have ports: reqN_data_i, reqN_key_i  input  128  plaintext/ciphertext and cipher key.
REQ-007 SHALL have ports: reqN_ack_o  output  1  request of N accepted this cycle.
REQ-008 SHALL have ports: resp_valid_o  output  1; resp_id_o  output  1; resp_data_o  output  128; resp_err_o  output  1; resp_accept_i  input  1.
REQ-009 SHALL have core-side ports: aes_load_o  output  1; aes_decrypt_o  output  1; aes_data_o  output  128; aes_key_o  output  128; aes_ready_i  input  1; aes_data_i  input  128.
REQ-010 SHALL have ports: busy_o  output  1  state!=IDLE; op_count_o  output  16  completed-operation count.

Function
REQ-011 SHALL implement FSM IDLE -> LOAD -> BUSY -> RESP -> IDLE.
REQ-012 IDLE: if any reqN_valid_i, SHALL grant one requester, assert its reqN_ack_o combinationally that cycle, register decrypt/data/key, and go to LOAD.
REQ-013 Arbitration SHALL be round-robin: if both valid, grant the one not granted last; if one valid, grant it; last_grant updates on every grant.
REQ-014 LOAD: aes_load_o SHALL be 1 for exactly one cycle, then go to BUSY.
REQ-015 aes_decrypt_o/aes_data_o/aes_key_o SHALL be driven from registers held constant from LOAD through the end of BUSY; core sees no change mid-operation.
REQ-016 BUSY: on aes_ready_i=1, SHALL capture aes_data_i into resp_data_o, set resp_err_o=0, increment op_count_o (wraps 0xFFFF->0), go to RESP.
REQ-017 RESP: resp_valid_o=1 with resp_id_o=granted index and resp_data_o stable until resp_accept_i=1; that cycle SHALL return to IDLE.
REQ-018 No reqN_ack_o SHALL assert outside IDLE; new requests stall while busy.
REQ-019 aes_ready_i outside BUSY SHALL be ignored.
REQ-020 Minimum turnaround: ack cycle + 1 LOAD cycle + core latency + 1 RESP cycle; back-to-back grant possible the cycle after resp_accept_i.
REQ-021 resp_accept_i outside RESP SHALL be ignored.

Reset
REQ-022 On reset low (any state, mid-operation included) SHALL go to IDLE immediately; all outputs 0, last_grant=1 (req0 wins first contention), op_count_o=0, timeout counter=0.
REQ-023 An in-flight result interrupted by reset SHALL be discarded.

Configuration
REQ-024 With AES_ARB_TIMEOUT_EN defined: counter SHALL clear on LOAD and increment each BUSY cycle; on reaching TIMEOUT_CYCLES without aes_ready_i, go to RESP with resp_err_o=1, resp_data_o=0, op_count_o unchanged.
REQ-025 Without AES_ARB_TIMEOUT_EN: no counter; resp_err_o tied 0; BUSY waits indefinitely.

Structure
REQ-026 SHALL put FSM state typedef (2-bit IDLE=0, LOAD=1, BUSY=2, RESP=3) and op-count width constant in shared package aes_arb_pkg.
REQ-027 SHALL instantiate one sub-module, aes_rr_arbiter (2-way round-robin grant, last_grant register).

Verification
REQ-028 Encrypt: req0 key 000102..0f, data 00112233445566778899aabbccddeeff -> resp_id_o=0, resp_data_o=69c4e0d86a7b0430d8cdb78070b4c55a, op_count_o=1.
REQ-029 Decrypt: req1 same key, data 69c4e0d8..c55a, decrypt=1 -> resp_id_o=1, resp_data_o=00112233..eeff.
REQ-030 Contention: both valid from reset -> grants 0,1,0,1 across four operations; no ack while busy_o=1.
REQ-031 Backpressure: hold resp_accept_i=0 for 20 cycles -> resp_valid_o/resp_data_o stable, no new ack; accept -> IDLE next cycle.
REQ-032 Reset mid-BUSY -> all outputs 0 next edge; subsequent stray aes_ready_i ignored; next request completes correctly.
REQ-033 With AES_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, aes_ready_i held 0 -> resp_valid_o=1, resp_err_o=1, resp_data_o=0 after 16 BUSY cycles.
